// File: rtl/phyreg_wrb_stage.sv
// Writeback stage: per-unit 2-entry result FIFOs feeding registered regfile write ports,
// plus the per-preg finish scoreboard. Define PHYREG_WRB_DUP_CHECK_EN for the duplicate-write checker.
module phyreg_wrb_stage #(
  parameter int REG_SIZE       = 64,
  parameter int REG_SIZE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      alu1_wrb_valid_i,
  output logic                      alu1_wrb_ready_o,
  input  logic [REG_SIZE_WIDTH-1:0] alu1_wrb_address_i,
  input  logic [63:0]               alu1_wrb_data_i,
  output logic [REG_SIZE_WIDTH-1:0] alu1_wrb_address_o,
  output logic [63:0]               alu1_wrb_data_o,
  output logic                      alu1_rcu_resp_valid_o,

  input  logic                      alu2_wrb_valid_i,
  output logic                      alu2_wrb_ready_o,
  input  logic [REG_SIZE_WIDTH-1:0] alu2_wrb_address_i,
  input  logic [63:0]               alu2_wrb_data_i,
  output logic [REG_SIZE_WIDTH-1:0] alu2_wrb_address_o,
  output logic [63:0]               alu2_wrb_data_o,
  output logic                      alu2_rcu_resp_valid_o,

  input  logic                      lsu_wrb_valid_i,
  output logic                      lsu_wrb_ready_o,
  input  logic [REG_SIZE_WIDTH-1:0] lsu_wrb_address_i,
  input  logic [63:0]               lsu_wrb_data_i,
  output logic [REG_SIZE_WIDTH-1:0] lsu_wrb_address_o,
  output logic [63:0]               lsu_wrb_data_o,
  output logic                      lsu_rcu_resp_valid_o,

  input  logic                      md_wrb_valid_i,
  output logic                      md_wrb_ready_o,
  input  logic [REG_SIZE_WIDTH-1:0] md_wrb_address_i,
  input  logic [63:0]               md_wrb_data_i,
  output logic [REG_SIZE_WIDTH-1:0] md_wrb_address_o,
  output logic [63:0]               md_wrb_data_o,
  output logic                      md_rcu_resp_valid_o,

  input  logic                      wrb_stall_i,

  input  logic                      alloc_first_valid_i,
  input  logic                      alloc_second_valid_i,
  input  logic [REG_SIZE_WIDTH-1:0] alloc_first_prd_i,
  input  logic [REG_SIZE_WIDTH-1:0] alloc_second_prd_i,

  input  logic [REG_SIZE_WIDTH-1:0] prs1_address_first_i,
  input  logic [REG_SIZE_WIDTH-1:0] prs2_address_first_i,
  input  logic [REG_SIZE_WIDTH-1:0] prs1_address_second_i,
  input  logic [REG_SIZE_WIDTH-1:0] prs2_address_second_i,
  output logic                      prs1_ready_first_o,
  output logic                      prs2_ready_first_o,
  output logic                      prs1_ready_second_o,
  output logic                      prs2_ready_second_o,

  output logic                      wrb_dup_err_o
);

  localparam int NSRC = 4;  // 0 alu1, 1 alu2, 2 lsu, 3 md

  typedef struct packed {
    logic [REG_SIZE_WIDTH-1:0] addr;
    logic [63:0]               data;
  } wrb_entry_t;

  logic [NSRC-1:0] in_valid;
  wrb_entry_t      in_entry [NSRC];
  logic [NSRC-1:0] ready, accept, push, pop, bypass;

  wrb_entry_t      fifo_mem [NSRC][2];
  logic [NSRC-1:0] wr_ptr, rd_ptr;
  logic [1:0]      count [NSRC];

  logic [NSRC-1:0] out_valid;
  wrb_entry_t      out_entry [NSRC];

  logic [REG_SIZE-1:0] finish, finish_next, set_mask, alloc_mask;

  assign in_valid    = {md_wrb_valid_i, lsu_wrb_valid_i, alu2_wrb_valid_i, alu1_wrb_valid_i};
  assign in_entry[0] = {alu1_wrb_address_i, alu1_wrb_data_i};
  assign in_entry[1] = {alu2_wrb_address_i, alu2_wrb_data_i};
  assign in_entry[2] = {lsu_wrb_address_i,  lsu_wrb_data_i};
  assign in_entry[3] = {md_wrb_address_i,   md_wrb_data_i};

  // With an empty FIFO and no stall the incoming result skips storage and lands in the output register.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      ready[s]  = (count[s] != 2'd2);
      accept[s] = in_valid[s] & ready[s];
      pop[s]    = !wrb_stall_i && (count[s] != 2'd0);
      bypass[s] = !wrb_stall_i && (count[s] == 2'd0) && accept[s];
      push[s]   = accept[s] && (wrb_stall_i || (count[s] != 2'd0));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= '0;
      for (int s = 0; s < NSRC; s++) begin
        count[s]     <= 2'd0;
        out_entry[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        count[s]     <= count[s] + 2'(push[s]) - 2'(pop[s]);
        wr_ptr[s]    <= wr_ptr[s] ^ push[s];
        rd_ptr[s]    <= rd_ptr[s] ^ pop[s];
        out_valid[s] <= pop[s] | bypass[s];
        if (pop[s])         out_entry[s] <= fifo_mem[s][rd_ptr[s]];
        else if (bypass[s]) out_entry[s] <= in_entry[s];
      end
    end
  end

  // NOTE: FIFO storage has no reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (push[s]) fifo_mem[s][wr_ptr[s]] <= in_entry[s];
    end
  end

  assign alu1_wrb_ready_o      = ready[0];
  assign alu2_wrb_ready_o      = ready[1];
  assign lsu_wrb_ready_o       = ready[2];
  assign md_wrb_ready_o        = ready[3];
  assign alu1_rcu_resp_valid_o = out_valid[0];
  assign alu2_rcu_resp_valid_o = out_valid[1];
  assign lsu_rcu_resp_valid_o  = out_valid[2];
  assign md_rcu_resp_valid_o   = out_valid[3];
  assign alu1_wrb_address_o    = out_entry[0].addr;
  assign alu2_wrb_address_o    = out_entry[1].addr;
  assign lsu_wrb_address_o     = out_entry[2].addr;
  assign md_wrb_address_o      = out_entry[3].addr;
  assign alu1_wrb_data_o       = out_entry[0].data;
  assign alu2_wrb_data_o       = out_entry[1].data;
  assign lsu_wrb_data_o        = out_entry[2].data;
  assign md_wrb_data_o         = out_entry[3].data;

  // Allocation beats a same-cycle writeback; P0 is hardwired finished.
  always_comb begin
    set_mask   = '0;
    alloc_mask = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (out_valid[s]) set_mask[out_entry[s].addr] = 1'b1;
    end
    if (alloc_first_valid_i)  alloc_mask[alloc_first_prd_i]  = 1'b1;
    if (alloc_second_valid_i) alloc_mask[alloc_second_prd_i] = 1'b1;
    finish_next    = (finish | set_mask) & ~alloc_mask;
    finish_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) finish <= '1;
    else     finish <= finish_next;
  end

  assign prs1_ready_first_o  = finish[prs1_address_first_i];
  assign prs2_ready_first_o  = finish[prs2_address_first_i];
  assign prs1_ready_second_o = finish[prs1_address_second_i];
  assign prs2_ready_second_o = finish[prs2_address_second_i];

`ifdef PHYREG_WRB_DUP_CHECK_EN
  logic dup_hit, dup_err;

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (out_valid[i] && out_entry[i].addr != '0) begin
        if (finish[out_entry[i].addr]) dup_hit = 1'b1;
        for (int j = i + 1; j < NSRC; j++) begin
          if (out_valid[j] && out_entry[j].addr == out_entry[i].addr) dup_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          dup_err <= 1'b0;
    else if (dup_hit) dup_err <= 1'b1;
  end

  assign wrb_dup_err_o = dup_err;
`else
  assign wrb_dup_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_phyreg_wrb_stage.sv
// Self-checking bench for phyreg_wrb_stage: per-source scoreboard on the write ports,
// a vector table of single results, and hand sequences for stall, alloc race, P0, reset and dup error.
module tb_phyreg_wrb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  v = '0;
  logic [5:0]  a [4];
  logic [63:0] d [4];
  logic [3:0]  rdy, ov;
  logic [5:0]  oa [4];
  logic [63:0] od [4];
  logic        stall = 1'b0;
  logic        al1_v = 1'b0, al2_v = 1'b0;
  logic [5:0]  al1_p = '0, al2_p = '0;
  logic [5:0]  q [4];
  logic [3:0]  qr;
  logic        dup_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  phyreg_wrb_stage dut (
    .clk(clk), .rst(rst),
    .alu1_wrb_valid_i(v[0]), .alu1_wrb_ready_o(rdy[0]), .alu1_wrb_address_i(a[0]), .alu1_wrb_data_i(d[0]),
    .alu1_wrb_address_o(oa[0]), .alu1_wrb_data_o(od[0]), .alu1_rcu_resp_valid_o(ov[0]),
    .alu2_wrb_valid_i(v[1]), .alu2_wrb_ready_o(rdy[1]), .alu2_wrb_address_i(a[1]), .alu2_wrb_data_i(d[1]),
    .alu2_wrb_address_o(oa[1]), .alu2_wrb_data_o(od[1]), .alu2_rcu_resp_valid_o(ov[1]),
    .lsu_wrb_valid_i(v[2]), .lsu_wrb_ready_o(rdy[2]), .lsu_wrb_address_i(a[2]), .lsu_wrb_data_i(d[2]),
    .lsu_wrb_address_o(oa[2]), .lsu_wrb_data_o(od[2]), .lsu_rcu_resp_valid_o(ov[2]),
    .md_wrb_valid_i(v[3]), .md_wrb_ready_o(rdy[3]), .md_wrb_address_i(a[3]), .md_wrb_data_i(d[3]),
    .md_wrb_address_o(oa[3]), .md_wrb_data_o(od[3]), .md_rcu_resp_valid_o(ov[3]),
    .wrb_stall_i(stall),
    .alloc_first_valid_i(al1_v), .alloc_second_valid_i(al2_v),
    .alloc_first_prd_i(al1_p), .alloc_second_prd_i(al2_p),
    .prs1_address_first_i(q[0]), .prs2_address_first_i(q[1]),
    .prs1_address_second_i(q[2]), .prs2_address_second_i(q[3]),
    .prs1_ready_first_o(qr[0]), .prs2_ready_first_o(qr[1]),
    .prs1_ready_second_o(qr[2]), .prs2_ready_second_o(qr[3]),
    .wrb_dup_err_o(dup_err)
  );

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected {addr,data} queued per source on accept, popped on resp_valid.
  logic [69:0] sb [4][$];

  always @(negedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++) sb[s].delete();
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (ov[s]) begin
          if (sb[s].size() == 0) check($sformatf("unexpected_write_src%0d", s), {oa[s], od[s]}, 70'h0);
          else check($sformatf("write_src%0d", s), {oa[s], od[s]}, sb[s].pop_front());
        end
        if (v[s] && rdy[s]) sb[s].push_back({a[s], d[s]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [5:0] p1, input logic [5:0] p2);
    al1_v = 1'b1; al1_p = p1;
    al2_v = 1'b1; al2_p = p2;
    tick();
    al1_v = 1'b0; al2_v = 1'b0;
  endtask

  task automatic query(input string name, input logic [5:0] p, input logic exp);
    q[0] = p;
    #1;
    check(name, 70'(qr[0]), 70'(exp));
  endtask

  typedef struct {
    int          src;
    logic [5:0]  addr;
    logic [63:0] data;
    logic        fin_after;
  } vec_t;

  vec_t vecs [6];

  initial begin
    for (int s = 0; s < 4; s++) begin
      a[s] = '0; d[s] = '0; q[s] = '0;
    end
    vecs[0] = '{0, 6'd6,  64'h1111_0000_0000_0001, 1'b1};
    vecs[1] = '{1, 6'd8,  64'h2222_3333_4444_5555, 1'b1};
    vecs[2] = '{2, 6'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[3] = '{3, 6'd14, 64'h0,                   1'b1};
    vecs[4] = '{0, 6'd63, 64'h8000_0000_0000_0000, 1'b1};
    vecs[5] = '{3, 6'd20, 64'h0123_4567_89AB_CDEF, 1'b1};

    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("reset_ready", 70'(rdy), 70'hF);
    check("reset_valid", 70'(ov), 70'h0);
    check("reset_addr_data", {oa[2], od[2]}, 70'h0);
    check("reset_dup_err", 70'(dup_err), 70'h0);
    query("reset_finish_33", 6'd33, 1'b1);

    // Single alu1 result, addr 5
    al1_v = 1'b1; al1_p = 6'd5; tick(); al1_v = 1'b0;
    query("alloc5_clears", 6'd5, 1'b0);
    v[0] = 1'b1; a[0] = 6'd5; d[0] = 64'hDEAD;
    tick();
    v[0] = 1'b0;
    check("alu1_latency", {oa[0], 63'h0, ov[0]}, {6'd5, 63'h0, 1'b1});
    check("alu1_data", 70'(od[0]), 70'hDEAD);
    query("finish5_not_forwarded", 6'd5, 1'b0);
    tick();
    check("alu1_valid_drop", 70'(ov[0]), 70'h0);
    query("finish5_set", 6'd5, 1'b1);

    // Table of single results
    for (int i = 0; i < 6; i++) begin
      al1_v = 1'b1; al1_p = vecs[i].addr; tick(); al1_v = 1'b0;
      query($sformatf("vec%0d_alloc", i), vecs[i].addr, 1'b0);
      v[vecs[i].src] = 1'b1; a[vecs[i].src] = vecs[i].addr; d[vecs[i].src] = vecs[i].data;
      tick();
      v[vecs[i].src] = 1'b0;
      check($sformatf("vec%0d_valid", i), 70'(ov), 70'(4'b1 << vecs[i].src));
      query($sformatf("vec%0d_fin_early", i), vecs[i].addr, 1'b0);
      tick();
      query($sformatf("vec%0d_fin", i), vecs[i].addr, vecs[i].fin_after);
    end

    // lsu three results under a 3-cycle stall
    alloc(6'd11, 6'd12);
    alloc(6'd13, 6'd13);
    stall = 1'b1;
    v[2] = 1'b1; a[2] = 6'd11; d[2] = 64'd1; tick();
    a[2] = 6'd12; d[2] = 64'd2; tick();
    a[2] = 6'd13; d[2] = 64'd3;
    #1;
    check("lsu_ready_full", 70'(rdy[2]), 70'h0);
    check("lsu_no_write_stall", 70'(ov[2]), 70'h0);
    tick();
    stall = 1'b0;
    check("lsu_ready_held", 70'(rdy[2]), 70'h0);
    tick();
    check("lsu_out1", {oa[2], 63'h0, ov[2]}, {6'd11, 63'h0, 1'b1});
    check("lsu_ready_back", 70'(rdy[2]), 70'h1);
    tick();
    v[2] = 1'b0;
    check("lsu_out2", {oa[2], 63'h0, ov[2]}, {6'd12, 63'h0, 1'b1});
    tick();
    check("lsu_out3", {oa[2], 63'h0, ov[2]}, {6'd13, 63'h0, 1'b1});
    tick();
    check("lsu_drained", 70'(ov[2]), 70'h0);

    // Alloc of 9 in the same cycle as md writes 9
    alloc(6'd9, 6'd9);
    v[3] = 1'b1; a[3] = 6'd9; d[3] = 64'h99; tick(); v[3] = 1'b0;
    check("md9_valid", 70'(ov[3]), 70'h1);
    al1_v = 1'b1; al1_p = 6'd9; tick(); al1_v = 1'b0;
    query("alloc_wins_9", 6'd9, 1'b0);
    tick();
    query("alloc_wins_9_hold", 6'd9, 1'b0);

    // All four sources at once
    alloc(6'd1, 6'd2);
    alloc(6'd3, 6'd4);
    for (int s = 0; s < 4; s++) begin
      v[s] = 1'b1; a[s] = 6'(s + 1); d[s] = 64'(100 + s);
    end
    tick();
    v = '0;
    check("four_valid", 70'(ov), 70'hF);
    q[0] = 6'd1; q[1] = 6'd2; q[2] = 6'd3; q[3] = 6'd4;
    #1;
    check("four_fin_early", 70'(qr), 70'h0);
    tick();
    check("four_fin", 70'(qr), 70'hF);

    // Writes to P0 pass through; P0 stays finished
    v[1] = 1'b1; a[1] = 6'd0; d[1] = 64'h5A5A; tick(); v[1] = 1'b0;
    check("p0_write", {oa[1], 63'h0, ov[1]}, {6'd0, 63'h0, 1'b1});
    query("p0_query", 6'd0, 1'b1);
    al1_v = 1'b1; al1_p = 6'd0; tick(); al1_v = 1'b0;
    query("p0_alloc_ignored", 6'd0, 1'b1);

    // Reset mid-operation drops buffered results
    stall = 1'b1;
    v[2] = 1'b1; a[2] = 6'd30; d[2] = 64'h30; tick(); tick();
    v[2] = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; stall = 1'b0;
    check("rst_ready", 70'(rdy), 70'hF);
    tick();
    check("rst_dropped", 70'(ov), 70'h0);
    query("rst_finish9", 6'd9, 1'b1);

`ifdef PHYREG_WRB_DUP_CHECK_EN
    alloc(6'd7, 6'd7);
    check("dup_clear", 70'(dup_err), 70'h0);
    v[0] = 1'b1; a[0] = 6'd7; d[0] = 64'h7;
    v[1] = 1'b1; a[1] = 6'd7; d[1] = 64'h77;
    tick();
    v = '0;
    tick();
    check("dup_set", 70'(dup_err), 70'h1);
    tick(); tick();
    check("dup_sticky", 70'(dup_err), 70'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("dup_rst", 70'(dup_err), 70'h0);
`else
    check("dup_tied_off", 70'(dup_err), 70'h0);
`endif

    tick(); tick();
    for (int s = 0; s < 4; s++) check($sformatf("sb_empty_src%0d", s), 70'(sb[s].size()), 70'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phyreg_wrb_stage.md
# phyreg_wrb_stage

Writeback stage between the four execution-unit result channels (alu1, alu2, lsu, md) and the physical register file's four write ports. It buffers each unit's results in a private 2-entry FIFO with valid/ready back-pressure. It drives registered write-port outputs to the regfile and keeps the per-preg finish-bit scoreboard that rename clears on allocation and issue queries on operand lookup.

## Interface
- REG_SIZE, 64, number of physical registers
- REG_SIZE_WIDTH, 6, preg address width
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- For each source s in {alu1, alu2, lsu, md}:
  - s_wrb_valid_i  input  1  result valid from unit
  - s_wrb_ready_o  output  1  stage can accept
  - s_wrb_address_i  input  REG_SIZE_WIDTH  destination preg
  - s_wrb_data_i  input  64  result data
  - s_wrb_address_o  output  REG_SIZE_WIDTH  to regfile write port
  - s_wrb_data_o  output  64  to regfile write port
  - s_rcu_resp_valid_o  output  1  regfile write enable
- wrb_stall_i  input  1  hold all write ports this cycle (rename recovery)
- alloc_first_valid_i, alloc_second_valid_i  input  1 each  rename allocates a preg
- alloc_first_prd_i, alloc_second_prd_i  input  REG_SIZE_WIDTH each  allocated preg
- prs1_address_first_i, prs2_address_first_i, prs1_address_second_i, prs2_address_second_i  input  REG_SIZE_WIDTH each  issue operand lookup
- prs1_ready_first_o, prs2_ready_first_o, prs1_ready_second_o, prs2_ready_second_o  output  1 each  finish bit of queried preg
- wrb_dup_err_o  output  1  sticky duplicate-write error

## Operation
- Per source FIFO, depth 2, count 0..2, wrapping 1-bit read and write pointers.
- s_wrb_ready_o = (count < 2). It is combinational from count only and never depends on valid.
- Accept = valid & ready. The payload is captured at the clock edge.
- Drain, each cycle, per source, independently:
  - If wrb_stall_i=1: no pop; s_rcu_resp_valid_o=0 next cycle.
  - Else if FIFO nonempty: pop the head into the output register; resp_valid=1 next cycle.
  - Else if accepting this cycle: bypass the incoming entry straight into the output register; the FIFO is not written.
  - Else resp_valid=0 next cycle.
- Simultaneous accept and pop on a full FIFO cannot occur, because ready=0 when full.
- Accept and pop in the same cycle at count=1 leaves count=1.
- Order is preserved per source. There is no ordering guarantee across sources.
- Finish scoreboard: REG_SIZE bits.
  - A bit is set at the end of every cycle in which s_rcu_resp_valid_o=1 for that address, i.e. on the same edge the regfile captures the data.
  - Alloc clears the bit at the edge.
  - Alloc and set on the same preg in the same cycle: alloc wins (bit=0).
  - first and second alloc of the same preg: cleared once.
- Bit 0 (P0) reads 1 always. Alloc and set of P0 are ignored. Writes with address 0 still pass through to the regfile, which discards them.
- Query outputs are combinational: ready_o = finish[address]. A set is not forwarded within the same cycle.

## Timing
- Reset values:
  - all FIFOs empty; all s_wrb_ready_o=1
  - all s_rcu_resp_valid_o=0; addresses and data outputs 0
  - all finish bits 1 (reset mapping is data 0, already final)
  - wrb_dup_err_o=0
- Latency with empty FIFO and no stall:
  - accept in cycle N gives resp_valid_o=1 in N+1
  - finish bit reads 1 from N+2
- With FIFO occupancy k, latency is 1+k cycles, plus 1 per stall cycle.
- wrb_stall_i does not affect ready. Up to 2 results per source buffer during a stall.
- rst mid-operation drops buffered results and output registers in one cycle.

## Configuration
- PHYREG_WRB_DUP_CHECK_EN defined:
  - wrb_dup_err_o sets when, in any cycle, two or more s_rcu_resp_valid_o are 1 with equal nonzero addresses.
  - The flag stays set until rst.
  - It also sets if any valid write targets a preg whose finish bit is already 1 (double writeback), address 0 excepted.
- Not defined: wrb_dup_err_o is tied 0 and the comparison logic is absent.

## Test plan
- Single alu1 result, addr 5, data 0xDEAD accepted in cycle 0 -> alu1_rcu_resp_valid_o=1, addr 5, data 0xDEAD in cycle 1; prs1_ready_first_o for addr 5 rises in cycle 2, after alloc of 5 cleared it beforehand.
- lsu back-to-back 3 results under wrb_stall_i=1 for 3 cycles -> ready drops after 2 accepts, third held by unit; release -> writes emerge in order 1,2,3 on consecutive cycles.
- Alloc of preg 9 coincident with md write of preg 9 -> finish[9]=0 after edge.
- All four sources valid same cycle to addrs 1,2,3,4 -> four resp_valid in the next cycle; all four finish bits set the cycle after.
- Write to addr 0 -> regfile port sees valid with addr 0; prs query on 0 stays 1; alloc of 0 has no effect.
- With PHYREG_WRB_DUP_CHECK_EN, alu1 and alu2 both writing addr 7 in the same cycle -> wrb_dup_err_o=1 next cycle, held until rst.
